// File: rtl/bus_seq_pkg.sv
// Shared types for the bus sequencer: FSM states, opcodes and the control-word layout
// produced by the decoder and consumed by the controller.
package bus_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_LDA = 4'h1;
  localparam opcode_t OP_ADD = 4'h2;
  localparam opcode_t OP_SUB = 4'h3;
  localparam opcode_t OP_OUT = 4'h4;
  localparam opcode_t OP_JMP = 4'h5;
  localparam opcode_t OP_JZ  = 4'h6;
  localparam opcode_t OP_LDI = 4'h7;
  localparam opcode_t OP_R8  = 4'h8;
  localparam opcode_t OP_R9  = 4'h9;
  localparam opcode_t OP_RA  = 4'hA;
  localparam opcode_t OP_RB  = 4'hB;
  localparam opcode_t OP_RC  = 4'hC;
  localparam opcode_t OP_RD  = 4'hD;
  localparam opcode_t OP_RE  = 4'hE;
  localparam opcode_t OP_HLT = 4'hF;

  // Control-word bit positions; bits 0..4 are the mutually exclusive bus drivers.
  localparam int CW_PC_OUT     = 0;
  localparam int CW_MEM_OUT    = 1;
  localparam int CW_IR_OUT     = 2;
  localparam int CW_A_OUT      = 3;
  localparam int CW_ALU_OUT    = 4;
  localparam int CW_PC_EN      = 5;
  localparam int CW_PC_LOAD    = 6;
  localparam int CW_MAR_LOAD   = 7;
  localparam int CW_A_LOAD     = 8;
  localparam int CW_B_LOAD     = 9;
  localparam int CW_OUT_LOAD   = 10;
  localparam int CW_ALU_SUB    = 11;
  localparam int CW_BUSY       = 12;
  localparam int CW_HALTED     = 13;
  localparam int CW_INSTR_DONE = 14;
  localparam int CW_W          = 15;

  typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/bus_seq_decode.sv
// Purely combinational map from (state, opcode, latched zero flag) to the control word.
module bus_seq_decode
  import bus_seq_pkg::*;
(
  input  state_t  state,
  input  opcode_t opcode,
  input  logic    z_q,
  output cw_t     cw
);

  always_comb begin
    // NOTE: default every bit first so no path through the case leaves cw unassigned (no latch).
    cw = '0;
    case (state)
      ST_T1: begin
        cw[CW_BUSY]     = 1'b1;
        cw[CW_PC_OUT]   = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      ST_T2: begin
        cw[CW_BUSY]    = 1'b1;
        cw[CW_MEM_OUT] = 1'b1;
        cw[CW_PC_EN]   = 1'b1;
      end
      ST_T3: begin
        cw[CW_BUSY]       = 1'b1;
        cw[CW_INSTR_DONE] = 1'b1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_INSTR_DONE] = 1'b0;
            cw[CW_IR_OUT]     = 1'b1;
            cw[CW_MAR_LOAD]   = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_OUT]    = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = 1'b1;
          end
          OP_JZ: begin
            cw[CW_IR_OUT]  = z_q;
            cw[CW_PC_LOAD] = z_q;
          end
          OP_LDI: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_A_LOAD] = 1'b1;
          end
          // HLT is not a completed instruction: it leaves for HALT instead of fetching.
          OP_HLT: cw[CW_INSTR_DONE] = 1'b0;
          default: ;
        endcase
      end
      ST_T4: begin
        cw[CW_BUSY]    = 1'b1;
        cw[CW_MEM_OUT] = 1'b1;
        if (opcode == OP_LDA) begin
          cw[CW_A_LOAD]     = 1'b1;
          cw[CW_INSTR_DONE] = 1'b1;
        end else begin
          cw[CW_B_LOAD] = 1'b1;
        end
      end
      ST_T5: begin
        cw[CW_BUSY]       = 1'b1;
        cw[CW_ALU_OUT]    = 1'b1;
        cw[CW_A_LOAD]     = 1'b1;
        cw[CW_ALU_SUB]    = (opcode == OP_SUB);
        cw[CW_INSTR_DONE] = 1'b1;
      end
      ST_HALT: cw[CW_HALTED] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_seq_ctrl.sv
// Instruction sequencer for a shared-bus accumulator machine: owns state, IR and the
// zero-flag snapshot; every output is decoded from those registers only.
module bus_seq_ctrl
  import bus_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [DW-1:0] bus_in,
  input  logic          zero_flag,
  output logic          pc_out_en,
  output logic          mem_out_en,
  output logic          ir_out_en,
  output logic          a_out_en,
  output logic          alu_out_en,
  output logic          pc_en,
  output logic          pc_load,
  output logic          mar_load,
  output logic          a_load,
  output logic          b_load,
  output logic          out_load,
  output logic          alu_sub,
  output logic [AW-1:0] opr,
  output logic          busy,
  output logic          halted,
  output logic          instr_done
);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] ir_q;
  logic          z_q;
  opcode_t       opcode;
  cw_t           cw;

  assign opcode = ir_q[DW-1:AW];

  bus_seq_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .z_q    (z_q),
    .cw     (cw)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (opcode == OP_HLT) state_d = ST_HALT;
        else if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) state_d = ST_T4;
      end
      ST_T4:   state_d = ST_T5;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    // The decoder's done flag marks the instruction boundary, the only point run is obeyed.
    if (cw[CW_INSTR_DONE]) state_d = run ? ST_T1 : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (state_q == ST_T2) begin
        ir_q <= bus_in;
        z_q  <= zero_flag;
      end
    end
  end

  assign pc_out_en  = cw[CW_PC_OUT];
  assign mem_out_en = cw[CW_MEM_OUT];
  assign ir_out_en  = cw[CW_IR_OUT];
  assign a_out_en   = cw[CW_A_OUT];
  assign alu_out_en = cw[CW_ALU_OUT];
  assign pc_en      = cw[CW_PC_EN];
  assign pc_load    = cw[CW_PC_LOAD];
  assign mar_load   = cw[CW_MAR_LOAD];
  assign a_load     = cw[CW_A_LOAD];
  assign b_load     = cw[CW_B_LOAD];
  assign out_load   = cw[CW_OUT_LOAD];
  assign alu_sub    = cw[CW_ALU_SUB];
  assign busy       = cw[CW_BUSY];
  assign halted     = cw[CW_HALTED];
  assign instr_done = cw[CW_INSTR_DONE];
  assign opr        = ir_q[AW-1:0];

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// Self-checking bench for bus_seq_ctrl: per-cycle expected control words queued from
// the opcode step table, compared at the falling edge.
module tb_bus_seq_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          zero_flag = 1'b0;
  logic pc_out_en, mem_out_en, ir_out_en, a_out_en, alu_out_en;
  logic pc_en, pc_load, mar_load, a_load, b_load, out_load, alu_sub;
  logic [AW-1:0] opr;
  logic busy, halted, instr_done;

  always #5 clk = ~clk;

  bus_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .bus_in(bus_in), .zero_flag(zero_flag),
    .pc_out_en(pc_out_en), .mem_out_en(mem_out_en), .ir_out_en(ir_out_en),
    .a_out_en(a_out_en), .alu_out_en(alu_out_en), .pc_en(pc_en), .pc_load(pc_load),
    .mar_load(mar_load), .a_load(a_load), .b_load(b_load), .out_load(out_load),
    .alu_sub(alu_sub), .opr(opr), .busy(busy), .halted(halted), .instr_done(instr_done)
  );

  // Bench-local output vector layout, MSB first; bits 14..10 are the bus drivers.
  localparam logic [14:0] PCO  = 15'h4000, MEMO = 15'h2000, IRO  = 15'h1000;
  localparam logic [14:0] AO   = 15'h0800, ALUO = 15'h0400, PCEN = 15'h0200;
  localparam logic [14:0] PCL  = 15'h0100, MARL = 15'h0080, AL   = 15'h0040;
  localparam logic [14:0] BL   = 15'h0020, OUTL = 15'h0010, SUB  = 15'h0008;
  localparam logic [14:0] BUSY = 15'h0004, HLTD = 15'h0002, DONE = 15'h0001;

  typedef struct {
    logic [14:0] cw;
    bit          chk_opr;
    logic [3:0]  opr;
    string       tag;
  } exp_t;

  typedef struct {
    bit         run;
    logic [7:0] bus;
    bit         zf;
  } stim_t;

  exp_t  sb[$];
  stim_t st[$];
  int    total = 0;
  int    bad = 0;

  function automatic logic [14:0] cw_now();
    return {pc_out_en, mem_out_en, ir_out_en, a_out_en, alu_out_en, pc_en, pc_load,
            mar_load, a_load, b_load, out_load, alu_sub, busy, halted, instr_done};
  endfunction

  // Each entry pairs the outputs expected in a cycle with the inputs driven during it.
  function automatic void push(logic [14:0] cw, bit chk, logic [3:0] o, string tag,
                               bit r, logic [7:0] b, bit z);
    exp_t  e;
    stim_t s;
    e.cw = cw; e.chk_opr = chk; e.opr = o; e.tag = tag;
    s.run = r; s.bus = b; s.zf = z;
    sb.push_back(e);
    st.push_back(s);
  endfunction

  function automatic void push_idle(int n, bit run_last);
    for (int i = 0; i < n; i++)
      push(15'h0, 1'b0, 4'h0, "idle", (i == n - 1) ? run_last : 1'b0, 8'h00, 1'b0);
  endfunction

  function automatic void push_instr(logic [7:0] ins, bit zf, bit run_mid, bit run_last);
    logic [3:0]  op = ins[7:4];
    logic [14:0] steps[$];
    bit          r;
    push(PCO | MARL | BUSY, 1'b0, 4'h0, "T1", 1'b1, ins, zf);
    push(MEMO | PCEN | BUSY, 1'b0, 4'h0, "T2", 1'b1, ins, zf);
    case (op)
      4'h1: steps = '{IRO | MARL | BUSY, MEMO | AL | BUSY | DONE};
      4'h2: steps = '{IRO | MARL | BUSY, MEMO | BL | BUSY, ALUO | AL | BUSY | DONE};
      4'h3: steps = '{IRO | MARL | BUSY, MEMO | BL | BUSY, ALUO | AL | SUB | BUSY | DONE};
      4'h4: steps = '{AO | OUTL | BUSY | DONE};
      4'h5: steps = '{IRO | PCL | BUSY | DONE};
      4'h6: steps = zf ? '{IRO | PCL | BUSY | DONE} : '{BUSY | DONE};
      4'h7: steps = '{IRO | AL | BUSY | DONE};
      4'hF: steps = '{BUSY};
      default: steps = '{BUSY | DONE};
    endcase
    for (int i = 0; i < steps.size(); i++) begin
      r = (i == 0 && steps.size() > 1) ? 1'b1 : (i == steps.size() - 1) ? run_last : run_mid;
      push(steps[i], steps[i][12], ins[3:0], $sformatf("op%h_T%0d", op, i + 3), r,
           8'($urandom), 1'($urandom_range(0, 1)));
    end
  endfunction

  task automatic pulse_reset_low();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    run = 1'b1; zero_flag = 1'b1; bus_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (cw_now() !== 15'h0) begin
        bad++; $display("FAIL reset_outputs cyc%0d: got %h want 0000", i, cw_now());
      end
      total++;
      if (opr !== 4'h0) begin
        bad++; $display("FAIL reset_opr cyc%0d: got %h want 0", i, opr);
      end
    end
    run = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_lda();
    exp_t e; stim_t s;
    push_idle(1, 1'b1);
    push_instr(8'h1E, 1'b0, 1'b1, 1'b1);
    push_instr(8'h00, 1'b0, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); s = st.pop_front();
      total++;
      if (cw_now() !== e.cw) begin
        bad++; $display("FAIL lda %s: got %h want %h", e.tag, cw_now(), e.cw);
      end
      if (e.chk_opr) begin
        total++;
        if (opr !== e.opr) begin bad++; $display("FAIL lda_opr %s: got %h want %h", e.tag, opr, e.opr); end
      end
      if (e.tag == "op1_T4") bus_in = 8'h2A;
      run = s.run; bus_in = (e.tag == "op1_T4") ? 8'h2A : s.bus; zero_flag = s.zf;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; stim_t s;
    push_idle(1, 1'b1);
    push_instr(8'h25, 1'b0, 1'b1, 1'b1);
    push_instr(8'h35, 1'b1, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); s = st.pop_front();
      total++;
      if (cw_now() !== e.cw) begin
        bad++; $display("FAIL add_sub %s: got %h want %h", e.tag, cw_now(), e.cw);
      end
      if (e.chk_opr) begin
        total++;
        if (opr !== e.opr) begin bad++; $display("FAIL add_sub_opr %s: got %h want %h", e.tag, opr, e.opr); end
      end
      run = s.run; bus_in = s.bus; zero_flag = s.zf;
    end
  endtask

  task automatic test_jz();
    exp_t e; stim_t s;
    push_idle(1, 1'b1);
    push_instr(8'h6A, 1'b1, 1'b1, 1'b1);
    push_instr(8'h6A, 1'b0, 1'b1, 1'b1);
    push_instr(8'h5C, 1'b0, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); s = st.pop_front();
      total++;
      if (cw_now() !== e.cw) begin
        bad++; $display("FAIL jz %s: got %h want %h", e.tag, cw_now(), e.cw);
      end
      if (e.chk_opr) begin
        total++;
        if (opr !== e.opr) begin bad++; $display("FAIL jz_opr %s: got %h want %h", e.tag, opr, e.opr); end
      end
      run = s.run; bus_in = s.bus; zero_flag = s.zf;
    end
  endtask

  task automatic test_pause();
    exp_t e; stim_t s;
    push_idle(1, 1'b1);
    push_instr(8'h27, 1'b0, 1'b0, 1'b0);
    push_idle(3, 1'b1);
    push_instr(8'h00, 1'b0, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); s = st.pop_front();
      total++;
      if (cw_now() !== e.cw) begin
        bad++; $display("FAIL pause %s: got %h want %h", e.tag, cw_now(), e.cw);
      end
      run = s.run; bus_in = s.bus; zero_flag = s.zf;
    end
  endtask

  task automatic test_all_opcodes();
    exp_t e; stim_t s;
    logic [14:0] now;
    bit rl;
    push_idle(1, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int op = 0; op < 15; op++) begin
        rl = 1'($urandom_range(0, 1));
        push_instr({4'(op), 4'($urandom)}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rl);
        if (!rl) push_idle($urandom_range(1, 3), 1'b1);
      end
    end
    push_instr(8'h00, 1'b0, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); s = st.pop_front();
      now = cw_now();
      total++;
      if (now !== e.cw) begin
        bad++; $display("FAIL opcodes %s: got %h want %h", e.tag, now, e.cw);
      end
      total++;
      if ($countones(now[14:10]) > 1) begin
        bad++; $display("FAIL bus_onehot %s: got drivers %b want at most one", e.tag, now[14:10]);
      end
      if (e.chk_opr) begin
        total++;
        if (opr !== e.opr) begin bad++; $display("FAIL opcodes_opr %s: got %h want %h", e.tag, opr, e.opr); end
      end
      run = s.run; bus_in = s.bus; zero_flag = s.zf;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; stim_t s;
    push_idle(1, 1'b1);
    push_instr(8'h25, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb.pop_front(); s = st.pop_front();
      total++;
      if (cw_now() !== e.cw) begin
        bad++; $display("FAIL reset_mid %s: got %h want %h", e.tag, cw_now(), e.cw);
      end
      run = s.run; bus_in = s.bus; zero_flag = s.zf;
    end
    sb.delete(); st.delete();
    pulse_reset_low();
    total++;
    if (cw_now() !== 15'h0) begin
      bad++; $display("FAIL reset_mid_async: got %h want 0000", cw_now());
    end
    total++;
    if (opr !== 4'h0) begin
      bad++; $display("FAIL reset_mid_opr: got %h want 0", opr);
    end
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_halt();
    exp_t e; stim_t s;
    push_idle(1, 1'b1);
    push_instr(8'hF0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++)
      push(HLTD, 1'b0, 4'h0, $sformatf("halt%0d", i), 1'(i % 2), 8'($urandom), 1'($urandom_range(0, 1)));
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); s = st.pop_front();
      total++;
      if (cw_now() !== e.cw) begin
        bad++; $display("FAIL halt %s: got %h want %h", e.tag, cw_now(), e.cw);
      end
      run = s.run; bus_in = s.bus; zero_flag = s.zf;
    end
    run = 1'b1;
    pulse_reset_low();
    total++;
    if (cw_now() !== 15'h0) begin
      bad++; $display("FAIL halt_reset: got %h want 0000", cw_now());
    end
    // Released with run already high: the first edge out of reset must start a fetch.
    @(negedge clk);
    rst_n = 1'b1;
    push_instr(8'h00, 1'b0, 1'b1, 1'b0);
    push_idle(1, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); s = st.pop_front();
      total++;
      if (cw_now() !== e.cw) begin
        bad++; $display("FAIL after_halt %s: got %h want %h", e.tag, cw_now(), e.cw);
      end
      run = s.run; bus_in = s.bus; zero_flag = s.zf;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lda();
    test_back_to_back();
    test_jz();
    test_pause();
    test_all_opcodes();
    test_reset_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_seq_ctrl.md
BUS_SEQ_CTRL -- requirements
Module: bus_seq_ctrl

Interface
REQ-001 Parameter DW, default 8: bus and instruction width.
REQ-002 Parameter AW, default 4: operand width; opcode width DW-AW SHALL equal 4.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 run  in  1  level; 1 = execute, 0 = pause at next instruction boundary.
REQ-006 bus_in  in  DW  current value of the shared bus, sampled as the instruction in T2.
REQ-007 zero_flag  in  1  accumulator-zero status.
REQ-008 Bus-driver enables, out, 1 each: pc_out_en, mem_out_en, ir_out_en, a_out_en, alu_out_en.
REQ-009 Load/strobe outputs, out, 1 each: pc_en (increment), pc_load, mar_load, a_load, b_load, out_load, alu_sub.
REQ-010 opr  out  AW  operand field of the instruction register, valid whenever ir_out_en=1.
REQ-011 busy, halted, instr_done  out  1 each: executing; in HALT; last step of an instruction.

Function
REQ-012 The FSM SHALL have states IDLE, T1, T2, T3, T4, T5, HALT.
- IDLE: go to T1 when run=1.
- T1: pc_out_en, mar_load.
- T2: mem_out_en, pc_en; latch IR<=bus_in and z_q<=zero_flag.
REQ-013 Opcode = IR[DW-1:AW]; T3-T5 actions per opcode:
- 0 NOP: T3 none.
- 1 LDA: T3 ir_out_en+mar_load; T4 mem_out_en+a_load.
- 2 ADD: T3 ir_out_en+mar_load; T4 mem_out_en+b_load; T5 alu_out_en+a_load.
- 3 SUB: as ADD, alu_sub=1 in T5 only.
- 4 OUT: T3 a_out_en+out_load.
- 5 JMP: T3 ir_out_en+pc_load.
- 6 JZ: T3 ir_out_en+pc_load if z_q=1, else no outputs.
- 7 LDI: T3 ir_out_en+a_load.
- 8-E: treated as NOP.
- F HLT: T3 no outputs; next state HALT.
REQ-014 After an instruction's last step (T3 for 0,4-E; T4 for 1; T5 for 2,3), instr_done SHALL be 1 for that cycle; next state T1 if run=1, else IDLE.
REQ-015 run=0 mid-instruction SHALL NOT abort it; pause takes effect only at the REQ-014 boundary; IDLE->T1 resume SHALL NOT disturb PC.
REQ-016 HALT SHALL be exited only by reset; run is ignored there.
REQ-017 At most one bus-driver enable SHALL be 1 in any cycle; all SHALL be 0 in IDLE and HALT.
REQ-018 All outputs SHALL be decoded from state, IR and z_q only; no combinational path from any input to any output.
REQ-019 busy=1 in T1-T5; halted=1 only in HALT.

Reset
REQ-020 While rst_n=0: state=IDLE, IR=0, z_q=0, opr=0, all enables/strobes/instr_done/busy/halted=0.
REQ-021 Reset asserted in any state, including mid-instruction or HALT, SHALL force REQ-020 immediately; first fetch T1 follows the first clock edge with rst_n=1 and run=1.

Structure
REQ-022 Package bus_seq_pkg SHALL hold the state enum, the opcode constants 0-F, and the control-word bit indices.
REQ-023 Sub-module bus_seq_decode SHALL be the purely combinational map (state, opcode, z_q) -> control word; bus_seq_ctrl holds state, IR and z_q registers.

Verification
REQ-024 run=1, mem[0]=0x1E, mem[14]=0x2A -> T1 pc_out_en+mar_load; T2 mem_out_en+pc_en; T3 ir_out_en+mar_load, opr=0xE; T4 mem_out_en+a_load, instr_done=1; then T1.
REQ-025 IR=0x25, then IR=0x35 -> 5-cycle sequences; alu_sub=0 for ADD; alu_sub=1 only in SUB T5; instr_done in T5.
REQ-026 IR=0x6A with zero_flag=1 at T2 -> T3 pc_load+ir_out_en, opr=0xA; with zero_flag=0 -> T3 all outputs 0, instr_done=1, then T1.
REQ-027 IR=0xF0 -> HALT, halted=1, busy=0, all outputs 0 for 10 cycles while run toggles; rst_n pulse -> IDLE.
REQ-028 run dropped in ADD T4 -> T5 completes, then IDLE with busy=0; run=1 again -> T1 next cycle, pc_out_en=1.
REQ-029 All opcodes 0-F under random run/zero_flag -> bus-driver one-hot-or-zero checked every cycle; opcodes 8-E take 3 cycles with no T3 outputs.
